prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-serial program loader that writes instruction memory for the 8-bit CPU core. The CPU only reads this memory.
- Receives a framed image from an external host over an 8-bit data bus plus a strobe. Writes bytes to consecutive memory addresses starting at 0, then verifies a checksum.
- Holds the CPU in reset until a valid image has been loaded. Sits between the top-level pins and the CPU memory write port.

Parameters:
- MEM_SIZE, 256, instruction memory depth in bytes (2..256).
- ADDR_W, 8, memory address width. Must satisfy 2^ADDR_W >= MEM_SIZE.
- SYNC_STAGES, 2, flip-flop stages in the strobe synchronizer (>=2).
- TIMEOUT_CYCLES, 65535, maximum idle clocks allowed between bytes inside a frame. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- byte_in  in  8  host data. Must be stable from before byte_stb rises until after byte_stb falls.
- byte_stb  in  1  host strobe, asynchronous to clk. One rising edge delivers one byte.
- mem_we  out  1  memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  8  memory write data.
- cpu_hold  out  1  high keeps the CPU in reset and PC at 0.
- busy  out  1  a frame is in progress.
- load_done  out  1  last frame was accepted.
- load_err  out  1  last frame was rejected.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, cpu_hold=1.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, load_done=0, load_err=0.
  - Synchronizer flops, counters and checksum all cleared.
- Strobe path:
  - byte_stb passes through SYNC_STAGES flops, then a rising-edge detector.
  - The edge cycle E is the only cycle in which byte_in is sampled.
  - Falling edges are ignored.
- Frame format: 0xA5 header, LEN, LEN data bytes, CSUM.
  - LEN=0 means 256 bytes.
  - CSUM = 8-bit sum (mod 256) of the data bytes only.
- State machine:
  - IDLE:
    - byte 0xA5 -> LEN. On entry: busy=1, cpu_hold=1, load_done=0, load_err=0, addr counter=0, sum=0.
    - Any other byte is ignored; stay in IDLE with flags unchanged.
  - LEN:
    - Capture count (0 -> 256).
    - If count > MEM_SIZE -> ERR.
    - Otherwise -> DATA.
  - DATA, each byte:
    - In cycle E+1: mem_we=1, mem_addr=counter, mem_wdata=byte.
    - sum += byte, counter++.
    - After the count-th byte -> CSUM.
  - CSUM:
    - byte == sum -> DONE: load_done=1, cpu_hold=0, busy=0.
    - Otherwise -> ERR.
  - ERR: load_err=1, busy=0, cpu_hold stays 1.
  - DONE and ERR behave as IDLE for new bytes: 0xA5 starts a new frame and reasserts cpu_hold in cycle E+1. Other bytes are ignored.
- mem_we:
  - High for exactly one cycle per data byte. Never high in any other state.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- Timeout:
  - In LEN, DATA and CSUM, an idle counter increments every cycle and clears on each edge.
  - When the counter reaches TIMEOUT_CYCLES -> ERR.
  - Memory already written is not rolled back.
- Simultaneous events:
  - An edge in the same cycle the timeout expires: the timeout wins and the byte is discarded.
  - rst during a frame aborts it. cpu_hold=1 and the next frame must begin with a header.
- Latency:
  - Flag and cpu_hold changes occur in cycle E+1 after the edge that causes them.
  - Pin-to-E latency is SYNC_STAGES+1 clocks.

Test Plan:
- Send A5 03 11 22 33 66 -> writes 0x11@0, 0x22@1, 0x33@2, each mem_we exactly one cycle; then load_done=1, cpu_hold=0, busy=0.
- Send A5 02 10 20 00 -> two writes occur, then load_err=1, cpu_hold=1, load_done=0. Then send A5 01 FF FF -> load_done=1, load_err=0.
- Send 00 7E A5 01 05 05 -> the leading 00 and 7E cause no writes; the frame is accepted and 0x05 is written at address 0.
- With TIMEOUT_CYCLES=100, send A5 04 01 and then hold byte_stb static for 100 clocks -> load_err=1, busy=0, no further mem_we.
- With MEM_SIZE=16, send A5 20 -> load_err=1 immediately after LEN, zero writes. With MEM_SIZE=256, send A5 00 + 256 bytes of 0x01 + 00 -> writes at addresses 0..255, load_done=1.
- Assert rst after the 2nd data byte of a 4-byte frame -> all outputs return to reset values immediately (cpu_hold=1). Subsequent data bytes are ignored until a new A5.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-serial instruction-memory loader: framed host image (A5, LEN, data, CSUM)
// is written from address 0 and the CPU is held in reset until a frame verifies.
module prog_loader #(
  parameter int MEM_SIZE       = 256,
  parameter int ADDR_W         = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_stb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [7:0]      HDR     = 8'hA5;
  localparam int              TO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [8:0]      MEM_LIM = 9'(MEM_SIZE);
  localparam logic            TO_EN   = (TIMEOUT_CYCLES != 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stb_q;
  logic                   r_edge;

  logic [2:0]        r_state;
  logic [8:0]        r_len;
  logic [8:0]        r_cnt;
  logic [7:0]        r_sum;
  logic [TO_W-1:0]   r_idle;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic       w_in_frame;
  logic       w_timeout;
  logic [8:0] w_len;
  logic [8:0] w_cnt_nxt;

  // Registering the edge makes pin-to-sample latency SYNC_STAGES+1 clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_stb_q <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], byte_stb};
      r_stb_q <= r_sync[SYNC_STAGES-1];
      r_edge  <= r_sync[SYNC_STAGES-1] & ~r_stb_q;
    end
  end

  assign w_in_frame = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timeout  = TO_EN && w_in_frame && (r_idle == TO_LIM);
  assign w_len      = (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
  assign w_cnt_nxt  = r_cnt + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (!w_in_frame || r_edge) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end

  // Timeout is checked first so a byte arriving in the expiry cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_timeout) begin
        r_state <= S_ERR;
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
      end else if (r_edge) begin
        case (r_state)
          S_LEN: begin
            if (w_len > MEM_LIM) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_len   <= w_len;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_we    <= 1'b1;
            r_addr  <= ADDR_W'(r_cnt);
            r_wdata <= byte_in;
            r_sum   <= r_sum + byte_in;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            r_busy <= 1'b0;
            if (byte_in == r_sum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          default: begin
            if (byte_in == HDR) begin
              r_state <= S_LEN;
              r_busy  <= 1'b1;
              r_hold  <= 1'b1;
              r_done  <= 1'b0;
              r_err   <= 1'b0;
              r_cnt   <= '0;
              r_sum   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_hold  = r_hold;
  assign busy      = r_busy;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: two instances (large memory with timeout,
// small memory without) share one host bus and are checked against a frame-level model.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_stb = 1'b0;

  logic       a_we, a_hold, a_busy, a_done, a_err;
  logic [7:0] a_addr, a_wdata;
  logic       b_we, b_hold, b_busy, b_done, b_err;
  logic [3:0] b_addr;
  logic [7:0] b_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader #(
    .MEM_SIZE(256), .ADDR_W(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)
  ) u_dut_a (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_stb(byte_stb),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .cpu_hold(a_hold), .busy(a_busy), .load_done(a_done), .load_err(a_err)
  );

  prog_loader #(
    .MEM_SIZE(16), .ADDR_W(4), .SYNC_STAGES(3), .TIMEOUT_CYCLES(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_stb(byte_stb),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .cpu_hold(b_hold), .busy(b_busy), .load_done(b_done), .load_err(b_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: phase 0 = waiting for header, 1 = length, 2 = data, 3 = checksum.
  int         m_ph[2];
  int         m_need[2];
  int         m_got[2];
  logic [7:0] m_sum[2];
  logic       m_busy[2], m_done[2], m_err[2], m_hold[2];
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_need[i] = 0; m_got[i] = 0; m_sum[i] = 8'h00;
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0; m_hold[i] = 1'b1;
    end
  endtask

  task automatic model_byte(input int i, input logic [7:0] b);
    int msize;
    int n;
    msize = (i == 0) ? 256 : 16;
    case (m_ph[i])
      0: if (b == 8'hA5) begin
        m_ph[i] = 1; m_busy[i] = 1'b1; m_hold[i] = 1'b1;
        m_done[i] = 1'b0; m_err[i] = 1'b0; m_got[i] = 0; m_sum[i] = 8'h00;
      end
      1: begin
        n = (b == 8'h00) ? 256 : int'(b);
        if (n > msize) begin
          m_ph[i] = 0; m_err[i] = 1'b1; m_busy[i] = 1'b0;
        end else begin
          m_need[i] = n; m_ph[i] = 2;
        end
      end
      2: begin
        if (i == 0) qa.push_back({8'(m_got[i]), b});
        else        qb.push_back({8'(m_got[i]), b});
        m_sum[i] = m_sum[i] + b;
        m_got[i] = m_got[i] + 1;
        if (m_got[i] == m_need[i]) m_ph[i] = 3;
      end
      default: begin
        m_ph[i] = 0; m_busy[i] = 1'b0;
        if (b == m_sum[i]) begin m_done[i] = 1'b1; m_hold[i] = 1'b0; end
        else m_err[i] = 1'b1;
      end
    endcase
  endtask

  task automatic model_timeout(input int i);
    if (m_ph[i] != 0) begin
      m_ph[i] = 0; m_err[i] = 1'b1; m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_a"}, {a_busy, a_done, a_err, a_hold}, {m_busy[0], m_done[0], m_err[0], m_hold[0]});
    chk({tag, "_b"}, {b_busy, b_done, b_err, b_hold}, {m_busy[1], m_done[1], m_err[1], m_hold[1]});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk); byte_in = b;
    @(negedge clk); byte_stb = 1'b1;
    repeat (6) @(negedge clk);
    byte_stb = 1'b0;
    repeat (5 + gap) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    model_byte(0, b);
    model_byte(1, b);
    send_byte(b, $urandom_range(0, 4));
    check_flags(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_flags(tag);
    chk({tag, "_a_out"}, {a_we, a_addr, a_wdata}, 17'h0);
    chk({tag, "_b_out"}, {b_we, b_addr, b_wdata}, 13'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Write monitor: every mem_we must match the next expected (addr,data) and last one cycle.
  logic a_we_q = 1'b0, b_we_q = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (a_we) begin
      chk("a_we_pulse", a_we_q, 1'b0);
      if (qa.size() == 0) chk("a_we_unexpected", a_we, 1'b0);
      else begin e = qa.pop_front(); chk("a_wr", {a_addr, a_wdata}, e); end
    end
    if (b_we) begin
      chk("b_we_pulse", b_we_q, 1'b0);
      if (qb.size() == 0) chk("b_we_unexpected", b_we, 1'b0);
      else begin e = qb.pop_front(); chk("b_wr", {4'h0, b_addr, b_wdata}, e); end
    end
    a_we_q = a_we;
    b_we_q = b_we;
  end

  initial begin
    logic [7:0] seq[$];
    logic [7:0] sum;
    int len;

    repeat (2) @(negedge clk);
    do_reset("reset");

    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    foreach (seq[k]) send(seq[k], "good3");

    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    foreach (seq[k]) send(seq[k], "badsum");
    seq = '{8'hA5, 8'h01, 8'hFF, 8'hFF};
    foreach (seq[k]) send(seq[k], "recover");

    seq = '{8'h00, 8'h7E, 8'hA5, 8'h01, 8'h05, 8'h05};
    foreach (seq[k]) send(seq[k], "junk");

    seq = '{8'hA5, 8'h04, 8'h01};
    foreach (seq[k]) send(seq[k], "to_pre");
    repeat (80) @(negedge clk);
    check_flags("to_wait");
    repeat (30) @(negedge clk);
    model_timeout(0);
    check_flags("to_exp");
    do_reset("reset2");

    seq = '{8'hA5, 8'h04, 8'h0A, 8'h0B};
    foreach (seq[k]) send(seq[k], "pre_rst");
    do_reset("midframe_rst");
    send(8'h0C, "post_rst");
    send(8'h0D, "post_rst");

    send(8'hA5, "len32");
    send(8'h20, "len32");
    sum = 8'h00;
    for (int k = 1; k <= 32; k++) begin
      send(8'(k), "len32_data");
      sum = sum + 8'(k);
    end
    send(sum, "len32_csum");

    send(8'hA5, "len256");
    send(8'h00, "len256");
    for (int k = 0; k < 256; k++) begin
      model_byte(0, 8'h01);
      model_byte(1, 8'h01);
      send_byte(8'h01, 0);
    end
    send(8'h00, "len256_csum");

    for (int f = 0; f < 40; f++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) send(8'($urandom_range(0, 8'hA4)), "rnd_junk");
      send(8'hA5, "rnd_hdr");
      len = $urandom_range(1, 24);
      send(8'(len), "rnd_len");
      sum = 8'h00;
      for (int k = 0; k < len; k++) begin
        logic [7:0] d;
        d = 8'($urandom);
        sum = sum + d;
        send(d, "rnd_data");
      end
      if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
      send(sum, "rnd_csum");
    end

    repeat (20) @(negedge clk);
    chk("a_pending_writes", qa.size(), 0);
    chk("b_pending_writes", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
